// File: rtl/serial_adder.sv
// serial_adder: multi-cycle LSB-first adder. It adds a + b + cin at CHUNK bits
// per clock through a registered carry, and uses valid/ready handshakes on both
// the operand side and the result side.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Reject parameter sets that cannot tile the operand evenly.
  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("serial_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] ca, cb;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] sum_nxt;
  logic             last;

  // Select the active chunk, add it with the running carry, and merge the result into sum.
  always_comb begin
    ca      = '0;
    cb      = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt == CW'(k)) begin
        ca = a_r[k*CHUNK +: CHUNK];
        cb = b_r[k*CHUNK +: CHUNK];
      end
    end
    csum    = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
    sum_nxt = sum;
    for (int k = 0; k < N; k++) begin
      if (cnt == CW'(k)) sum_nxt[k*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    end
    last    = (cnt == CW'(N-1));
  end

  // Control FSM and datapath registers. All handshake outputs are registered.
  // The carry into the MSB equals a_msb ^ b_msb ^ sum_msb, so XOR-ing that
  // with the final carry gives signed overflow at any CHUNK size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end
        ADD: begin
          sum   <= sum_nxt;
          carry <= csum[CHUNK];
          cnt   <= cnt + CW'(1);
          if (last) begin
            cout      <= csum[CHUNK];
            overflow  <= ca[CHUNK-1] ^ cb[CHUNK-1] ^ csum[CHUNK-1] ^ csum[CHUNK];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks on an 8-bit/1-bit instance (corner sums,
// handshake stall, ignored input, mid-operation reset) and exhaustive checks
// on 4-bit instances with CHUNK=4 and CHUNK=2.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // 8-bit, 1 bit per cycle
  logic       iv8 = 1'b0, or8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ir8, ov8, co8, of8;
  logic [7:0] s8;

  serial_adder #(.WIDTH(8), .CHUNK(1)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .overflow(of8));

  // 4-bit instances share operands; out_ready is held high
  logic       iv4 = 1'b0, c4 = 1'b0, or4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ir4a, ov4a, co4a, of4a, ir4b, ov4b, co4b, of4b;
  logic [3:0] s4a, s4b;

  serial_adder #(.WIDTH(4), .CHUNK(4)) u_d4a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4a), .a(a4), .b(b4), .cin(c4),
    .out_valid(ov4a), .out_ready(or4), .sum(s4a), .cout(co4a), .overflow(of4a));

  serial_adder #(.WIDTH(4), .CHUNK(2)) u_d4b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4b), .a(a4), .b(b4), .cin(c4),
    .out_valid(ov4b), .out_ready(or4), .sum(s4b), .cout(co4b), .overflow(of4b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start8(input logic [7:0] aa, input logic [7:0] bb, input logic cc);
    @(negedge clk);
    a8 = aa; b8 = bb; c8 = cc; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume8();
    @(negedge clk);
    or8 = 1'b1;
    @(posedge clk); #1;
    chk("consume in_ready", 32'(ir8), 32'd1);
    chk("consume out_valid", 32'(ov8), 32'd0);
    @(negedge clk);
    or8 = 1'b0;
  endtask

  int lat;
  int cyc, la, lb;
  logic gota, gotb;
  logic [5:0] ra, rb, exp4;
  logic [8:0] v;
  logic [4:0] r5;

  initial begin
    // Reset state
    #12;
    chk("rst in_ready", 32'(ir8), 32'd1);
    chk("rst out_valid", 32'(ov8), 32'd0);
    chk("rst sum", 32'(s8), 32'h00);
    chk("rst cout", 32'(co8), 32'd0);
    chk("rst overflow", 32'(of8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // FF + 01 -> 00, carry out, no signed overflow
    start8(8'hFF, 8'h01, 1'b0);
    chk("ff busy in_ready", 32'(ir8), 32'd0);
    wait8(lat);
    chk("ff latency", 32'(lat), 32'd8);
    chk("ff sum", 32'(s8), 32'h00);
    chk("ff cout", 32'(co8), 32'd1);
    chk("ff ovf", 32'(of8), 32'd0);
    consume8();

    // 0F + F0 + 1 -> 00, carry out
    start8(8'h0F, 8'hF0, 1'b1);
    wait8(lat);
    chk("0f latency", 32'(lat), 32'd8);
    chk("0f sum", 32'(s8), 32'h00);
    chk("0f cout", 32'(co8), 32'd1);
    chk("0f ovf", 32'(of8), 32'd0);
    consume8();

    // 7F + 01 -> 80 with signed overflow; a 0x11 request is held during ADD/DONE
    start8(8'h7F, 8'h01, 1'b0);
    a8 = 8'h11; b8 = 8'h22; c8 = 1'b1; iv8 = 1'b1;
    wait8(lat);
    chk("7f latency", 32'(lat), 32'd8);
    chk("7f sum", 32'(s8), 32'h80);
    chk("7f cout", 32'(co8), 32'd0);
    chk("7f ovf", 32'(of8), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall sum", 32'(s8), 32'h80);
      chk("stall ovf", 32'(of8), 32'd1);
      chk("stall out_valid", 32'(ov8), 32'd1);
      chk("stall in_ready", 32'(ir8), 32'd0);
    end
    @(negedge clk);
    iv8 = 1'b0;
    consume8();
    @(posedge clk); #1;
    chk("idle after consume", 32'(ir8), 32'd1);
    chk("sum held after consume", 32'(s8), 32'h80);

    // Reset during the 4th ADD cycle
    start8(8'hAA, 8'h55, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(ov8), 32'd0);
    chk("midrst sum", 32'(s8), 32'h00);
    chk("midrst in_ready", 32'(ir8), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    start8(8'h03, 8'h04, 1'b0);
    wait8(lat);
    chk("post-rst latency", 32'(lat), 32'd8);
    chk("post-rst sum", 32'(s8), 32'h07);
    chk("post-rst cout", 32'(co8), 32'd0);
    chk("post-rst ovf", 32'(of8), 32'd0);
    consume8();

    // Exhaustive 4-bit checks for CHUNK=4 and CHUNK=2
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      @(negedge clk);
      a4 = v[3:0]; b4 = v[7:4]; c4 = v[8]; iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      cyc = 0; la = 0; lb = 0; gota = 1'b0; gotb = 1'b0; ra = '0; rb = '0;
      while (!(gota && gotb) && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
        if (ov4a && !gota) begin gota = 1'b1; la = cyc; ra = {of4a, co4a, s4a}; end
        if (ov4b && !gotb) begin gotb = 1'b1; lb = cyc; rb = {of4b, co4b, s4b}; end
      end
      r5 = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]};
      exp4 = {(v[3] == v[7]) && (r5[3] != v[3]), r5};
      chk("w4c4 result", 32'(ra), 32'(exp4));
      chk("w4c4 latency", 32'(la), 32'd1);
      chk("w4c2 result", 32'(rb), 32'(exp4));
      chk("w4c2 latency", 32'(lb), 32'd2);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
